hex_display_ctrl: RTL and testbench



---
 rtl/hex_display_pkg.sv | 24 ++
 rtl/hex_display.sv | 32 +++
 rtl/hex_display_ctrl.sv | 116 +++++++++++
 tb/tb_hex_display_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the seven-segment display controller.
// Holds the blank segment code, the FSM state encoding and the counter width helpers.
// Contents: SEG_BLANK, state_e, idx_width(), ps_width().
package hex_display_pkg;

  // All segments off (active-low outputs).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Digit index width; at least one bit even for a single digit.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  // Prescaler width for a counter running over 0..div-1.
  function automatic int ps_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/hex_display.sv
// Purpose: hex nibble to active-low seven-segment decoder (bit 6 = g ... bit 0 = a).
// Ports: nibble_i (4-bit value), seg_o (7-bit active-low segment pattern).
// Latency: purely combinational; no backpressure.
module hex_display (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h18;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Purpose: latches a packed hex value and scans it MSB digit first through one shared
//   decoder into per-digit segment registers, with blank mask, leading-zero blanking
//   and a prescaler that periodically rescans the shadow value.
// Latency: accept at edge k writes digit DIGITS-1 at k+1 ... digit 0 at k+DIGITS.
// Backpressure: load_ready_o is high only in IDLE; it stays low for DIGITS cycles per scan.
// Ports: clk_i, rst_i (sync, active-high), load_valid_i/load_ready_o handshake,
//   load_value_i (nibble i -> digit i), load_blank_i (bit i blanks digit i),
//   load_lz_i (leading-zero blanking), hex_o (7 active-low bits per digit, registered).
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [4*DIGITS-1:0]   load_value_i,
  input  logic [DIGITS-1:0]     load_blank_i,
  input  logic                  load_lz_i,
  output logic [7*DIGITS-1:0]   hex_o
);

  localparam int                PS_W     = ps_width(REFRESH_DIV);
  localparam int                IDX_W    = idx_width(DIGITS);
  localparam logic [PS_W-1:0]   PS_MAX   = PS_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  state_e                state_q;
  logic [PS_W-1:0]       ps_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  nz_q;
  logic [4*DIGITS-1:0]   val_q;
  logic [DIGITS-1:0]     mask_q;
  logic                  lz_q;
  logic [7*DIGITS-1:0]   hex_q;

  logic                  ps_tick;
  logic [3:0]            nib_d;
  logic                  msk_d;
  logic                  blank_d;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_d;

  assign ps_tick      = (ps_q == PS_MAX);
  assign load_ready_o = (state_q == ST_IDLE);
  assign hex_o        = hex_q;

  // Shadow nibble and mask bit selected by the current scan index.
  always_comb begin
    nib_d = 4'h0;
    msk_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_d = val_q[4*i +: 4];
        msk_d = mask_q[i];
      end
    end
  end

  hex_display u_dec (
    .nibble_i (nib_d),
    .seg_o    (dec_seg)
  );

  // Digit 0 is exempt from leading-zero blanking so a zero value still shows "0".
  assign blank_d = msk_d | (lz_q & ~nz_q & (nib_d == 4'h0) & (idx_q != '0));
  assign seg_d   = blank_d ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ps_q    <= '0;
      idx_q   <= '0;
      nz_q    <= 1'b0;
      val_q   <= '0;
      mask_q  <= '1;
      lz_q    <= 1'b0;
      hex_q   <= '1;
    end else begin
      // Free-running; scan entry below overrides this with a restart at zero.
      ps_q <= ps_tick ? '0 : ps_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          // A load takes priority over a coincident tick; either starts one scan.
          if (load_valid_i) begin
            val_q   <= load_value_i;
            mask_q  <= load_blank_i;
            lz_q    <= load_lz_i;
            idx_q   <= IDX_LAST;
            nz_q    <= 1'b0;
            ps_q    <= '0;
            state_q <= ST_SCAN;
          end else if (ps_tick) begin
            idx_q   <= IDX_LAST;
            nz_q    <= 1'b0;
            ps_q    <= '0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) hex_q[7*i +: 7] <= seg_d;
          end
          // A masked nonzero digit still ends the leading-zero run.
          nz_q <= nz_q | (nib_d != 4'h0);
          if (idx_q == '0) state_q <= ST_IDLE;
          else             idx_q   <= idx_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

  localparam int DIGITS = 6;
  localparam int REFRESH_DIV = 8;
  localparam logic [41:0] ALL_BLANK = 42'h3FFFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [23:0] load_value = '0;
  logic [5:0]  load_blank = '0;
  logic        load_lz = 1'b0;
  logic [41:0] hex;

  int checks = 0;
  int errors = 0;

  hex_display_ctrl #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_value_i (load_value),
    .load_blank_i (load_blank),
    .load_lz_i    (load_lz),
    .hex_o        (hex)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!load_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", 64'(load_ready), 64'd1);
  endtask

  // Offers one value, returns #1 after the accepting edge with the inputs scrambled.
  task automatic do_load(input logic [23:0] v, input logic [5:0] m, input logic lz);
    wait_ready();
    load_valid = 1'b1;
    load_value = v;
    load_blank = m;
    load_lz    = lz;
    step();
    load_valid = 1'b0;
    load_value = 24'($urandom);
    load_blank = 6'($urandom);
    load_lz    = 1'($urandom);
  endtask

  initial begin
    int bad;
    int low;
    int acc;

    // Reset: 3 cycles, then display blank and ready.
    repeat (3) step();
    chk("reset_hex", 64'(hex), 64'(ALL_BLANK));
    chk("reset_ready", 64'(load_ready), 64'd1);
    rst = 1'b0;
    bad = 0;
    low = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (hex !== ALL_BLANK) bad++;
      if (!load_ready) low++;
    end
    chk("reset_rescan_blank", 64'(bad), 64'd0);
    chk("reset_rescan_seen", 64'(low > 0), 64'd1);

    // Leading-zero load; ready low exactly 6 cycles.
    do_load(24'h000105, 6'b000000, 1'b1);
    low = 0;
    for (int c = 0; c < 6; c++) begin
      if (!load_ready) low++;
      step();
    end
    chk("lz_ready_low", 64'(low), 64'd6);
    chk("lz_ready_back", 64'(load_ready), 64'd1);
    chk("lz_hex", 64'(hex), 64'({7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h12}));

    // Zero value with and without leading-zero blanking.
    do_load(24'h000000, 6'b000000, 1'b1);
    repeat (6) step();
    chk("zero_lz_hex", 64'(hex), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
    do_load(24'h000000, 6'b000000, 1'b0);
    repeat (6) step();
    chk("zero_nolz_hex", 64'(hex), 64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}));

    // Inner zeros survive once a nonzero digit has been seen.
    do_load(24'h100200, 6'b000000, 1'b1);
    repeat (6) step();
    chk("inner_zero_hex", 64'(hex), 64'({7'h79, 7'h40, 7'h40, 7'h24, 7'h40, 7'h40}));

    // Busy handshake: valid held 10 cycles from an accept -> exactly two accepts.
    wait_ready();
    load_valid = 1'b1;
    load_value = 24'h123456;
    load_blank = 6'b000000;
    load_lz    = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (load_ready) acc++;
      step();
    end
    load_valid = 1'b0;
    chk("busy_accepts", 64'(acc), 64'd2);
    repeat (4) step();
    chk("busy_ready_back", 64'(load_ready), 64'd1);
    chk("busy_hex", 64'(hex), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));
    chk("busy_digit0", 64'(hex[6:0]), 64'(7'b0000010));

    // Mask with leading zeros: masked nonzero digit 1 is blank.
    do_load(24'h000099, 6'b000010, 1'b1);
    repeat (6) step();
    chk("mask_hex", 64'(hex), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h18}));

    // Letters through the decoder; then tick and load collide at the 8th cycle.
    do_load(24'hABCDEF, 6'b000000, 1'b0);
    repeat (6) step();
    chk("letters_hex", 64'(hex), 64'({7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}));
    step();
    chk("collide_ready", 64'(load_ready), 64'd1);
    load_valid = 1'b1;
    load_value = 24'h100200;
    load_blank = 6'b000000;
    load_lz    = 1'b1;
    step();
    load_valid = 1'b0;
    chk("collide_busy", 64'(load_ready), 64'd0);
    repeat (6) step();
    chk("collide_hex", 64'(hex), 64'({7'h79, 7'h40, 7'h40, 7'h24, 7'h40, 7'h40}));
    chk("collide_ready_back", 64'(load_ready), 64'd1);
    step();
    chk("collide_single_scan", 64'(load_ready), 64'd1);

    // Periodic refresh: 12 busy cycles in 16, display unchanged.
    low = 0;
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (!load_ready) low++;
      if (hex !== {7'h79, 7'h40, 7'h40, 7'h24, 7'h40, 7'h40}) bad++;
    end
    chk("refresh_low_cycles", 64'(low), 64'd12);
    chk("refresh_hex_stable", 64'(bad), 64'd0);

    // Reset on the third scan cycle.
    do_load(24'h123456, 6'b000000, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("midrst_hex", 64'(hex), 64'(ALL_BLANK));
    chk("midrst_ready", 64'(load_ready), 64'd1);
    rst = 1'b0;
    bad = 0;
    low = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (hex !== ALL_BLANK) bad++;
      if (!load_ready) low++;
    end
    chk("midrst_refresh_blank", 64'(bad), 64'd0);
    chk("midrst_refresh_seen", 64'(low > 0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
